// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - job sequencer feeding skewed A/B edges into a SIZE x SIZE systolic array
// Optional SYSTOLIC_PERF_CNT_EN adds jobs_done / stall_cycles counters.
`timescale 1ns/1ps
module systolic_feed_ctrl #(
  parameter int WIDTHx = 5,
  parameter int SIZE   = 4,
  parameter int PE_LAT = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SIZE*SIZE*WIDTHx-1:0]   a_matrix,
  input  logic [SIZE*SIZE*WIDTHx-1:0]   b_matrix,
  output logic                          arr_clear,
  output logic                          arr_en,
  output logic [SIZE*WIDTHx-1:0]        a_edge,
  output logic [SIZE*WIDTHx-1:0]        b_edge,
  output logic                          res_valid,
  input  logic                          res_ready,
`ifdef SYSTOLIC_PERF_CNT_EN
  output logic [15:0]                   jobs_done,
  output logic [15:0]                   stall_cycles,
`endif
  output logic                          busy
);

  localparam int TW = $clog2(3*SIZE+PE_LAT);
  localparam int MW = SIZE*SIZE*WIDTHx;
  localparam int EW = SIZE*WIDTHx;
  localparam logic [TW-1:0] FEED_LAST  = TW'(2*SIZE-2);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(SIZE-2+PE_LAT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d;
  logic [EW-1:0] a_edge_q, a_edge_d, b_edge_q, b_edge_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_matrix;
          b_d     = b_matrix;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == FEED_LAST) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edges are computed for the upcoming step so they leave the block from flops.
  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < SIZE; i++) begin
        if (int'(t_d) >= i && int'(t_d) - i < SIZE) begin
          a_edge_d[i*WIDTHx +: WIDTHx] = a_q[(i*SIZE + int'(t_d) - i)*WIDTHx +: WIDTHx];
          b_edge_d[i*WIDTHx +: WIDTHx] = b_q[((int'(t_d) - i)*SIZE + i)*WIDTHx +: WIDTHx];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_edge_q <= '0;
      b_edge_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign arr_clear = (state_q == CLEAR);
  assign arr_en    = (state_q == FEED) || (state_q == DRAIN);
  assign res_valid = (state_q == DONE);
  assign a_edge    = a_edge_q;
  assign b_edge    = b_edge_q;

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [15:0] jobs_q, stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jobs_q  <= '0;
      stall_q <= '0;
    end else if (state_q == DONE) begin
      if (res_ready) jobs_q <= jobs_q + 16'd1;
      else if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign jobs_done    = jobs_q;
  assign stall_cycles = stall_q;
`endif

endmodule
